// File: rtl/bus_initiator_if.sv
// rtl/bus_initiator_if.sv - command/response handshake and peripheral register bus bundle for bus_initiator
interface bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [4:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, RD,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, A, WD, WE
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, RD,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, A, WD, WE
    );
endinterface

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - one-command-at-a-time READ/WRITE/RMW/POLL initiator for the peripheral register bus
// POLL support is built only when BUS_INITIATOR_POLL_EN is defined; otherwise op 11 answers with an error.
module bus_initiator #(
    parameter int POLL_MAX = 1000
) (
    input  logic            clk,
    input  logic            rst,
    bus_initiator_if.master bus
);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RMW   = 2'b10;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_RESP = 3'd4;
`ifdef BUS_INITIATOR_POLL_EN
    localparam logic [2:0] S_POLL = 3'd3;
    localparam int         CW      = $clog2(POLL_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(POLL_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
`endif

    if (POLL_MAX < 1 || POLL_MAX > 65535) begin : g_poll_max_check
        $error("bus_initiator: POLL_MAX out of range");
    end

    logic [2:0]  state;
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] mask;
`ifdef BUS_INITIATOR_POLL_EN
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          poll_hit;

    assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign poll_hit = (bus.RD & mask) == (data & mask);
`endif

    assign bus.cmd_ready = (state == S_IDLE) && !rst;
    assign bus.rsp_valid = (state == S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op           <= OP_READ;
            data         <= '0;
            mask         <= '0;
            bus.A        <= '0;
            bus.WD       <= '0;
            bus.WE       <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
`ifdef BUS_INITIATOR_POLL_EN
            cnt          <= '0;
`endif
        end else begin
            bus.WE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op          <= bus.cmd_op;
                        data        <= bus.cmd_data;
                        mask        <= bus.cmd_mask;
                        bus.A       <= bus.cmd_addr;
                        bus.rsp_err <= 1'b0;
                        // WRITE is launched from the accept edge so WE lands in the EXEC cycle.
                        if (bus.cmd_op == OP_WRITE) begin
                            bus.WE <= 1'b1;
                            bus.WD <= bus.cmd_data;
                        end
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_READ: begin
                            bus.rsp_data <= bus.RD;
                            state        <= S_RESP;
                        end
                        OP_WRITE: begin
                            bus.rsp_data <= data;
                            state        <= S_RESP;
                        end
                        OP_RMW: begin
                            bus.WD <= (bus.RD & ~mask) | (data & mask);
                            bus.WE <= 1'b1;
                            state  <= S_WB;
                        end
                        default: begin
`ifdef BUS_INITIATOR_POLL_EN
                            cnt   <= '0;
                            state <= S_POLL;
`else
                            bus.rsp_data <= '0;
                            bus.rsp_err  <= 1'b1;
                            state        <= S_RESP;
`endif
                        end
                    endcase
                end
                S_WB: begin
                    bus.rsp_data <= bus.WD;
                    state        <= S_RESP;
                end
`ifdef BUS_INITIATOR_POLL_EN
                S_POLL: begin
                    bus.rsp_data <= bus.RD;
                    cnt          <= cnt_next;
                    // A match on the final sample still counts as success.
                    if (poll_hit) begin
                        bus.rsp_err <= 1'b0;
                        state       <= S_RESP;
                    end else if (cnt_next == CNT_MAX) begin
                        bus.rsp_err <= 1'b1;
                        state       <= S_RESP;
                    end
                end
`endif
                S_RESP: begin
                    if (bus.rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - table-driven scoreboard bench for bus_initiator with a small register-file bus model
module tb_bus_initiator;
`ifdef BUS_INITIATOR_POLL_EN
    localparam bit POLL_ON = 1'b1;
`else
    localparam bit POLL_ON = 1'b0;
`endif
    localparam int PMAX = 8;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] mask;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_we_cyc;
        logic [31:0] exp_wd;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_initiator_if bif();

    bus_initiator #(.POLL_MAX(PMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    logic [31:0] mem [32];
    logic [31:0] ctr;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem[0] <= 32'h1234;
            mem[4] <= 32'hF0F0;
        end else if (bif.WE) begin
            mem[bif.A] <= bif.WD;
        end
    end

    // Address 12 is a free-running counter that reads 0 in the first POLL cycle after accept.
    always @(posedge clk) begin
        if (bif.cmd_valid && bif.cmd_ready) ctr <= 32'hFFFF_FFFF;
        else                                ctr <= ctr + 32'd1;
    end

    assign bif.RD = (bif.A == 5'd12) ? ctr : mem[bif.A];

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int stall);
        int   guard;
        int   lat;
        int   we_cnt;
        int   we_cyc;
        logic [31:0] wd_s;
        logic [4:0]  a_s;
        exp_t e;
        lat = 0; we_cnt = 0; we_cyc = 0; wd_s = '0; a_s = '0;
        @(negedge clk);
        bif.rsp_ready = (stall == 0);
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = v.op;
        bif.cmd_addr  = v.addr;
        bif.cmd_data  = v.data;
        bif.cmd_mask  = v.mask;
        guard = 0;
        while (!bif.cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bif.cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bif.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bif.cmd_valid = 1'b0;
        sb.push_back('{data: v.exp_data, err: v.exp_err});
        for (int j = 1; j <= 40 && lat == 0; j++) begin
            @(negedge clk);
            if (bif.WE) begin
                we_cnt++;
                we_cyc = j;
                wd_s   = bif.WD;
                a_s    = bif.A;
            end
            if (bif.rsp_valid) lat = j;
        end
        check("rsp_latency", lat, v.exp_lat);
        e = sb.pop_front();
        check("rsp_data", bif.rsp_data, e.data);
        check("rsp_err", {31'd0, bif.rsp_err}, {31'd0, e.err});
        check("we_pulses", we_cnt, (v.exp_we_cyc != 0) ? 1 : 0);
        if (v.exp_we_cyc != 0) begin
            check("we_cycle", we_cyc, v.exp_we_cyc);
            check("we_wd", wd_s, v.exp_wd);
            check("we_addr", {27'd0, a_s}, {27'd0, v.addr});
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, bif.rsp_valid}, 32'd1);
            check("stall_data", bif.rsp_data, e.data);
            check("stall_err", {31'd0, bif.rsp_err}, {31'd0, e.err});
            check("stall_cmd_ready", {31'd0, bif.cmd_ready}, 32'd0);
            check("stall_we", {31'd0, bif.WE}, 32'd0);
        end
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_rsp", {31'd0, bif.cmd_ready}, 32'd1);
        check("rsp_valid_dropped", {31'd0, bif.rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bif.cmd_valid = 1'b0;
        bif.cmd_op    = 2'b00;
        bif.cmd_addr  = '0;
        bif.cmd_data  = '0;
        bif.cmd_mask  = '0;
        bif.rsp_ready = 1'b1;

        //          op     addr   data          mask          exp_data      err   lat                  we wd
        vt[0]  = '{2'b00, 5'd0,  32'h0,        32'h0,        32'h1234,     1'b0, 2,                   0, 32'h0};
        vt[1]  = '{2'b10, 5'd4,  32'h55,       32'hFF,       32'hF055,     1'b0, 3,                   2, 32'hF055};
        vt[2]  = '{2'b00, 5'd4,  32'h0,        32'h0,        32'hF055,     1'b0, 2,                   0, 32'h0};
        vt[3]  = '{2'b01, 5'd4,  32'hA5,       32'h0,        32'hA5,       1'b0, 2,                   1, 32'hA5};
        vt[4]  = '{2'b00, 5'd4,  32'h0,        32'h0,        32'hA5,       1'b0, 2,                   0, 32'h0};
        vt[5]  = '{2'b01, 5'd31, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 2,                   1, 32'hDEADBEEF};
        vt[6]  = '{2'b00, 5'd31, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 2,                   0, 32'h0};
        vt[7]  = '{2'b00, 5'd20, 32'h0,        32'h0,        32'h0,        1'b0, 2,                   0, 32'h0};
        vt[8]  = '{2'b10, 5'd31, 32'h12345678, 32'hFFFF0000, 32'h1234BEEF, 1'b0, 3,                   2, 32'h1234BEEF};
        vt[9]  = '{2'b11, 5'd12, 32'h5,        32'hFFFFFFFF, POLL_ON ? 32'h5 : 32'h0, !POLL_ON, POLL_ON ? 8 : 2, 0, 32'h0};
        vt[10] = '{2'b11, 5'd13, 32'h1,        32'h1,        32'h0,        1'b1, POLL_ON ? 2 + PMAX : 2, 0, 32'h0};
        vt[11] = '{2'b11, 5'd12, 32'h0,        32'hFFFFFFFF, 32'h0,        !POLL_ON, POLL_ON ? 3 : 2, 0, 32'h0};
        vt[12] = '{2'b11, 5'd12, 32'h7,        32'hFFFFFFFF, POLL_ON ? 32'h7 : 32'h0, !POLL_ON, POLL_ON ? 2 + PMAX : 2, 0, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_A", {27'd0, bif.A}, 32'd0);
        check("rst_WD", bif.WD, 32'd0);
        check("rst_WE", {31'd0, bif.WE}, 32'd0);
        check("rst_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
        check("rst_rsp_data", bif.rsp_data, 32'd0);
        check("rst_rsp_err", {31'd0, bif.rsp_err}, 32'd0);
        check("rst_cmd_ready", {31'd0, bif.cmd_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", {31'd0, bif.cmd_ready}, 32'd1);

        for (int i = 0; i < 13; i++) run_vec(vt[i], 0);

        // Response held off for three cycles.
        run_vec(vt[0], 3);

        // Reset while a POLL (or its error response) is in flight.
        @(negedge clk);
        bif.rsp_ready = 1'b0;
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = 2'b11;
        bif.cmd_addr  = 5'd13;
        bif.cmd_data  = 32'h1;
        bif.cmd_mask  = 32'h1;
        @(posedge clk);
        #1 bif.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_WE", {31'd0, bif.WE}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
        check("mid_rst_rsp_data", bif.rsp_data, 32'd0);
        check("mid_rst_rsp_err", {31'd0, bif.rsp_err}, 32'd0);
        check("mid_rst_A", {27'd0, bif.A}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, bif.cmd_ready}, 32'd0);
        rst = 1'b0;
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, bif.cmd_ready}, 32'd1);
        check("post_rst_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
        run_vec(vt[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
